fetch_unit: RTL

Instruction-fetch stage of the single-cycle-plus-memory-wait datapath. It holds the architectural PC register and issues read requests to instruction memory over a req/rdy handshake. It latches the returned word and presents it to decode over a valid/ack handshake. It exports the current PC to the branch/next-PC logic and loads the next-PC value computed there when decode accepts an instruction.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_unit_pc_reg.sv | 23 ++
 rtl/fetch_unit.sv | 117 +++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_FETCH  = 2'b01,
    ST_HOLD   = 2'b10,
    ST_HALTED = 2'b11
  } fetch_state_e;

  localparam logic [15:0] RESET_PC_DEFAULT   = 16'h0000;
  localparam logic [3:0]  HLT_OPCODE_DEFAULT = 4'hF;

  // Instructions are halfword-aligned, so bit 0 of any PC candidate is dropped.
  function automatic logic [15:0] align_pc(input logic [15:0] pc);
    return {pc[15:1], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// 16-bit PC register with load enable and asynchronous reset to RESET_PC.
module pc_reg
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] d,
  output logic [15:0] q
);

  // Hold the PC; take the new value only when load is asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RESET_PC;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads instruction memory over
// req/rdy, and hands each word to decode over valid/ack.
//
// state     | meaning
// ----------+-------------------------------------------------------
// ST_IDLE   | single cycle after reset release, no request
// ST_FETCH  | imem_req high at pc_cur, waiting for imem_rdy
// ST_HOLD   | inst_valid high, waiting for decode to ack
// ST_HALTED | HLT fetched, all inputs ignored until reset
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter logic [3:0]  HLT_OPCODE = HLT_OPCODE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_rdy,
  input  logic [15:0] imem_data,
  output logic [15:0] pc_cur,
  input  logic [15:0] pc_next,
  output logic [15:0] inst,
  output logic        inst_valid,
  input  logic        inst_ack,
  output logic        halt,
  output logic [15:0] fetch_count
);

  fetch_state_e state_q;
  fetch_state_e state_d;
  logic         mem_done;
  logic         accept;
  logic         is_hlt;
  logic [15:0]  pc_load_val;
  logic [15:0]  inst_q;
  logic [15:0]  count_q;

  assign mem_done    = (state_q == ST_FETCH) && imem_rdy;
  assign accept      = (state_q == ST_HOLD) && inst_ack;
  assign is_hlt      = (imem_data[15:12] == HLT_OPCODE);
  assign pc_load_val = align_pc(pc_next);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and state-decoded handshake outputs.
  always_comb begin
    state_d    = state_q;
    imem_req   = 1'b0;
    inst_valid = 1'b0;
    halt       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_rdy) begin
          state_d = is_hlt ? ST_HALTED : ST_HOLD;
        end
      end
      ST_HOLD: begin
        inst_valid = 1'b1;
        if (inst_ack) begin
          state_d = ST_FETCH;
        end
      end
      ST_HALTED: begin
        halt = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Capture the returned word, HLT included, so decode/debug can see it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_q <= 16'h0000;
    end else if (mem_done) begin
      inst_q <= imem_data;
    end
  end

  // Count instructions consumed by decode; wraps silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 16'h0000;
    end else if (accept) begin
      count_q <= count_q + 16'd1;
    end
  end

  pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk  (clk),
    .rst_n(rst_n),
    .load (accept),
    .d    (pc_load_val),
    .q    (pc_cur)
  );

  assign imem_addr   = pc_cur;
  assign inst        = inst_q;
  assign fetch_count = count_q;

endmodule
